bsk_prd_poll_ctrl: RTL and testbench

//  Bus-master sequencer that polls the two PRD command-receiver boards (CS 4'b1011 = commands 16..01,
//  CS 4'b1001 = commands 32..17) over the shared 16-bit parallel bus. Per board it checks the
//  ID/password register, reads both command registers and writes the indication register.

---
 rtl/bsk_prd_poll_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bsk_prd_poll_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsk_prd_poll_ctrl.sv
// Bus-master poll sequencer for the two PRD command-receiver boards.
// Per board: check ID/password (A=11), read commands (A=00, A=01), write
// the inverted indication word (A=10). Every access is SETUP/STROBE/HOLD.
module bsk_prd_poll_ctrl #(
  parameter int         T_SETUP  = 2,
  parameter int         T_STB    = 4,
  parameter int         T_HOLD   = 1,
  parameter logic [7:0] PASSWORD = 8'hA4
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iStart,
  input  logic [15:0] iInd0,
  input  logic [15:0] iInd1,
  input  logic [15:0] iDIn,
  output logic [15:0] oDOut,
  output logic        oDOe,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  output logic [31:0] oCom0,
  output logic [31:0] oCom1,
  output logic [1:0]  oErr,
  output logic        oBusy,
  output logic        oDone
);

  localparam int T_MAX_AB = (T_SETUP > T_STB) ? T_SETUP : T_STB;
  localparam int T_MAX    = (T_MAX_AB > T_HOLD) ? T_MAX_AB : T_HOLD;
  localparam int CW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] STB_LAST   = CW'(T_STB - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [3:0] CS_BOARD0 = 4'b1011;
  localparam logic [3:0] CS_BOARD1 = 4'b1001;
  localparam logic [3:0] CS_NONE   = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Chip-select code of a slot.
  function automatic logic [3:0] slotCs(input logic slot);
    return slot ? CS_BOARD1 : CS_BOARD0;
  endfunction

  // Register address of each access step.
  function automatic logic [1:0] stepAddr(input logic [1:0] step);
    logic [1:0] addr;
    case (step)
      2'd0:    addr = 2'b11;
      2'd1:    addr = 2'b00;
      2'd2:    addr = 2'b01;
      2'd3:    addr = 2'b10;
      default: addr = 2'b11;
    endcase
    return addr;
  endfunction

  state_t        state_r, stateNxt_s;
  logic [CW-1:0] cnt_r, cntNxt_s, lastCnt_s;
  logic [1:0]    step_r, stepNxt_s;
  logic          slot_r, slotNxt_s;
  logic [15:0]   ind0_r, ind1_r, temp_r;
  logic          atLast_s, sample_s, active_s, isWr_s;
  logic [3:0]    csNxt_s;
  logic [1:0]    aNxt_s;
  logic          rdNxt_s, wrNxt_s, doeNxt_s, busyNxt_s, doneNxt_s;
  logic [15:0]   doutNxt_s;

  // Terminal count of the current phase and the read-sample point.
  always_comb begin
    lastCnt_s = CNT_ZERO;
    case (state_r)
      SETUP:   lastCnt_s = SETUP_LAST;
      STROBE:  lastCnt_s = STB_LAST;
      HOLD:    lastCnt_s = HOLD_LAST;
      default: lastCnt_s = CNT_ZERO;
    endcase
    atLast_s = (cnt_r == lastCnt_s);
    sample_s = (state_r == STROBE) && atLast_s && (step_r != 2'd3);
  end

  // Next-state logic: walk the access list, skipping a board whose ID fails.
  always_comb begin
    stateNxt_s = state_r;
    cntNxt_s   = cnt_r;
    stepNxt_s  = step_r;
    slotNxt_s  = slot_r;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          stateNxt_s = SETUP;
          cntNxt_s   = CNT_ZERO;
          stepNxt_s  = 2'd0;
          slotNxt_s  = 1'b0;
        end else begin
          stateNxt_s = IDLE;
        end
      end
      SETUP: begin
        if (atLast_s) begin
          stateNxt_s = STROBE;
          cntNxt_s   = CNT_ZERO;
        end else begin
          cntNxt_s   = cnt_r + CNT_ONE;
        end
      end
      STROBE: begin
        if (atLast_s) begin
          stateNxt_s = HOLD;
          cntNxt_s   = CNT_ZERO;
        end else begin
          cntNxt_s   = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        if (atLast_s) begin
          cntNxt_s = CNT_ZERO;
          // oErr[slot_r] was updated at the step-0 sample edge
          if ((step_r == 2'd3) || ((step_r == 2'd0) && oErr[slot_r])) begin
            if (slot_r) begin
              stateNxt_s = DONE;
            end else begin
              stateNxt_s = SETUP;
              slotNxt_s  = 1'b1;
              stepNxt_s  = 2'd0;
            end
          end else begin
            stateNxt_s = SETUP;
            stepNxt_s  = step_r + 2'd1;
          end
        end else begin
          cntNxt_s = cnt_r + CNT_ONE;
        end
      end
      DONE:    stateNxt_s = IDLE;
      default: stateNxt_s = IDLE;
    endcase
  end

  // Bus output values for the next clock, derived from the next state.
  always_comb begin
    active_s  = (stateNxt_s == SETUP) || (stateNxt_s == STROBE) || (stateNxt_s == HOLD);
    isWr_s    = (stepNxt_s == 2'd3);
    csNxt_s   = active_s ? slotCs(slotNxt_s) : CS_NONE;
    aNxt_s    = active_s ? stepAddr(stepNxt_s) : 2'b00;
    rdNxt_s   = !((stateNxt_s == STROBE) && !isWr_s);
    wrNxt_s   = !((stateNxt_s == STROBE) && isWr_s);
    doeNxt_s  = active_s && isWr_s;
    // boards show ~reg10 on their indicators, so write the inverse
    doutNxt_s = doeNxt_s ? ~(slotNxt_s ? ind1_r : ind0_r) : 16'h0000;
    busyNxt_s = (stateNxt_s != IDLE);
    doneNxt_s = (stateNxt_s == DONE);
  end

  // State, counters, registered bus outputs and captured board data.
  always_ff @(posedge clk) begin
    if (iRes) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      step_r  <= 2'd0;
      slot_r  <= 1'b0;
      ind0_r  <= 16'h0000;
      ind1_r  <= 16'h0000;
      temp_r  <= 16'h0000;
      oCS     <= CS_NONE;
      oA      <= 2'b00;
      oRd     <= 1'b1;
      oWr     <= 1'b1;
      oDOe    <= 1'b0;
      oDOut   <= 16'h0000;
      oCom0   <= 32'h0000_0000;
      oCom1   <= 32'h0000_0000;
      oErr    <= 2'b00;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      state_r <= stateNxt_s;
      cnt_r   <= cntNxt_s;
      step_r  <= stepNxt_s;
      slot_r  <= slotNxt_s;
      oCS     <= csNxt_s;
      oA      <= aNxt_s;
      oRd     <= rdNxt_s;
      oWr     <= wrNxt_s;
      oDOe    <= doeNxt_s;
      oDOut   <= doutNxt_s;
      oBusy   <= busyNxt_s;
      oDone   <= doneNxt_s;
      if ((state_r == IDLE) && iStart) begin
        ind0_r <= iInd0;
        ind1_r <= iInd1;
      end
      if (sample_s) begin
        case (step_r)
          2'd0: oErr[slot_r] <= (iDIn[15:8] != PASSWORD);
          2'd1: temp_r <= iDIn;
          2'd2: begin
            if (slot_r) begin
              oCom1 <= {iDIn, temp_r};
            end else begin
              oCom0 <= {iDIn, temp_r};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsk_prd_poll_ctrl.sv
// Bench for bsk_prd_poll_ctrl: two instances (default timing and 1/1/1
// timing) talk to the same simple board register model. Stimulus pushes
// expected round results; a negedge monitor pops them on oDone and also
// watches strobe timing and reset values continuously.
module tb_bsk_prd_poll_ctrl;

  logic              clk = 1'b0;
  logic              iRes;
  logic [1:0]        start;
  logic [15:0]       ind0, ind1;
  logic [1:0][15:0]  dIn, dOut;
  logic [1:0]        dOe, rd, wr, busy, done;
  logic [1:0][3:0]   cs;
  logic [1:0][1:0]   a, err;
  logic [1:0][31:0]  com0, com1;

  logic [15:0] bReg [2][4];

  typedef struct {
    logic [31:0] com0;
    logic [31:0] com1;
    logic [1:0]  err;
    int          acc0, acc1, wc0, wc1;
    logic [15:0] wv0, wv1;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nChk = 0;
  int nPass = 0;
  logic endReq = 1'b0;
  logic endAck = 1'b0;

  always #5 clk = ~clk;

  bsk_prd_poll_ctrl #(.T_SETUP(2), .T_STB(4), .T_HOLD(1), .PASSWORD(8'hA4)) dut0 (
    .clk(clk), .iRes(iRes), .iStart(start[0]), .iInd0(ind0), .iInd1(ind1),
    .iDIn(dIn[0]), .oDOut(dOut[0]), .oDOe(dOe[0]), .oCS(cs[0]), .oA(a[0]),
    .oRd(rd[0]), .oWr(wr[0]), .oCom0(com0[0]), .oCom1(com1[0]), .oErr(err[0]),
    .oBusy(busy[0]), .oDone(done[0])
  );

  bsk_prd_poll_ctrl #(.T_SETUP(1), .T_STB(1), .T_HOLD(1), .PASSWORD(8'hA4)) dut1 (
    .clk(clk), .iRes(iRes), .iStart(start[1]), .iInd0(ind0), .iInd1(ind1),
    .iDIn(dIn[1]), .oDOut(dOut[1]), .oDOe(dOe[1]), .oCS(cs[1]), .oA(a[1]),
    .oRd(rd[1]), .oWr(wr[1]), .oCom0(com0[1]), .oCom1(com1[1]), .oErr(err[1]),
    .oBusy(busy[1]), .oDone(done[1])
  );

  function automatic int tSet(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int tStb(input int i);
    return (i == 0) ? 4 : 1;
  endfunction
  function automatic int tHold(input int i);
    return 1;
  endfunction

  // Board register model: read data for whichever board is selected.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i] == 4'b1011) begin
        dIn[i] = bReg[0][a[i]];
      end else if (cs[i] == 4'b1001) begin
        dIn[i] = bReg[1][a[i]];
      end else begin
        dIn[i] = 16'hFFFF;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    nChk++;
    if (act === expv) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  // Monitor state
  logic        resSeen = 1'b0;
  logic        prvRd[2] = '{1'b1, 1'b1};
  logic        prvWr[2] = '{1'b1, 1'b1};
  logic        prvBusy[2] = '{1'b0, 1'b0};
  logic [3:0]  prvCs[2] = '{4'hF, 4'hF};
  logic [1:0]  prvA[2] = '{2'b00, 2'b00};
  int          lowCnt[2], stab[2], holdCnt[2], runCnt[2];
  bit          holdPend[2];
  int          acc[2][2], wc[2][2];
  logic [15:0] wv[2][2];
  logic [15:0] lastWd[2];

  // Monitor: reset values, strobe timing, round results against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic chg, stb, pstb;
      exp_t e;
      int   qs;
      if (resSeen) begin
        check($sformatf("u%0d reset_outputs", i),
              {cs[i], a[i], rd[i], wr[i], dOe[i], dOut[i], com0[i], com1[i], err[i], busy[i], done[i]},
              {4'hF, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0});
        lowCnt[i] = 0; stab[i] = 0; holdCnt[i] = 0; holdPend[i] = 1'b0;
      end else begin
        chg  = (cs[i] != prvCs[i]) || (a[i] != prvA[i]);
        stb  = !rd[i] || !wr[i];
        pstb = !prvRd[i] || !prvWr[i];
        if (stb && !pstb) begin
          check($sformatf("u%0d setup_time", i), stab[i], tSet(i));
          lowCnt[i] = 1;
        end else if (stb) begin
          check($sformatf("u%0d cs_a_stable_in_strobe", i), chg, 1'b0);
          lowCnt[i]++;
        end
        if (!stb && pstb) begin
          check($sformatf("u%0d strobe_width", i), lowCnt[i], tStb(i));
          holdPend[i] = 1'b1;
          holdCnt[i]  = chg ? 0 : 1;
          if (prvCs[i] == 4'b1011) begin
            acc[i][0]++;
            if (!prvWr[i]) begin wc[i][0]++; wv[i][0] = lastWd[i]; end
          end else if (prvCs[i] == 4'b1001) begin
            acc[i][1]++;
            if (!prvWr[i]) begin wc[i][1]++; wv[i][1] = lastWd[i]; end
          end else begin
            check($sformatf("u%0d cs_code_in_strobe", i), prvCs[i], 4'b1011);
          end
        end else if (!stb && holdPend[i]) begin
          if (chg) begin
            check($sformatf("u%0d hold_time", i), holdCnt[i], tHold(i));
            holdPend[i] = 1'b0;
          end else begin
            holdCnt[i]++;
          end
        end
        if (!rd[i]) begin
          check($sformatf("u%0d rd_wr_exclusive", i), wr[i], 1'b1);
          check($sformatf("u%0d rd_doe_off", i), dOe[i], 1'b0);
        end
        if (!wr[i]) begin
          check($sformatf("u%0d wr_doe_on", i), dOe[i], 1'b1);
          lastWd[i] = dOut[i];
        end
        stab[i] = (cs[i] == 4'hF) ? 0 : (chg ? 1 : stab[i] + 1);

        if (busy[i] && !prvBusy[i]) begin
          runCnt[i] = 0;
          for (int b = 0; b < 2; b++) begin acc[i][b] = 0; wc[i][b] = 0; wv[i][b] = 16'h0; end
        end else if (busy[i]) begin
          runCnt[i]++;
        end

        if (done[i]) begin
          qs = (i == 0) ? q0.size() : q1.size();
          check($sformatf("u%0d done_expected", i), (qs > 0), 1'b1);
          if (qs > 0) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("u%0d com0", i), com0[i], e.com0);
            check($sformatf("u%0d com1", i), com1[i], e.com1);
            check($sformatf("u%0d err", i), err[i], e.err);
            check($sformatf("u%0d round_len", i), runCnt[i], (e.acc0 + e.acc1) * (tSet(i) + tStb(i) + tHold(i)));
            check($sformatf("u%0d accesses_b0", i), acc[i][0], e.acc0);
            check($sformatf("u%0d accesses_b1", i), acc[i][1], e.acc1);
            check($sformatf("u%0d writes_b0", i), wc[i][0], e.wc0);
            check($sformatf("u%0d writes_b1", i), wc[i][1], e.wc1);
            if (e.wc0 > 0) check($sformatf("u%0d reg10_b0", i), wv[i][0], e.wv0);
            if (e.wc1 > 0) check($sformatf("u%0d reg10_b1", i), wv[i][1], e.wv1);
          end
        end
      end
      prvRd[i] = rd[i]; prvWr[i] = wr[i]; prvCs[i] = cs[i]; prvA[i] = a[i]; prvBusy[i] = busy[i];
    end
    resSeen = iRes;
    if (endReq && !endAck) begin
      check("u0 leftover_expectations", q0.size(), 0);
      check("u1 leftover_expectations", q1.size(), 0);
      endAck = 1'b1;
    end
  end

  task automatic pushExp(input logic [1:0] m, input exp_t e);
    if (m[0]) q0.push_back(e);
    if (m[1]) q1.push_back(e);
  endtask

  task automatic startRound(input logic [1:0] m, input logic [15:0] i0, input logic [15:0] i1);
    @(posedge clk); #1;
    ind0 = i0; ind1 = i1; start = m;
    @(posedge clk); #1;
    start = 2'b00;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (busy == 2'b00) break;
    end
  endtask

  task automatic setBoard(input int b, input logic [15:0] r11, input logic [15:0] r00, input logic [15:0] r01);
    bReg[b][3] = r11; bReg[b][0] = r00; bReg[b][1] = r01; bReg[b][2] = 16'h0000;
  endtask

  initial begin
    exp_t e;
    iRes = 1'b1; start = 2'b11; ind0 = 16'h0; ind1 = 16'h0;
    setBoard(0, 16'h0, 16'h0, 16'h0);
    setBoard(1, 16'h0, 16'h0, 16'h0);
    // 1: reset with iStart held high
    repeat (3) @(posedge clk);
    #1 iRes = 1'b0; start = 2'b00;
    repeat (2) @(posedge clk);

    // 2: both boards healthy
    setBoard(0, 16'hA462, 16'hC3E1, 16'hE1C3);
    setBoard(1, 16'hA400, 16'h1234, 16'h5678);
    e = '{com0: 32'hE1C3C3E1, com1: 32'h56781234, err: 2'b00, acc0: 4, acc1: 4,
          wc0: 1, wc1: 1, wv0: 16'h6DCE, wv1: 16'hF0F0};
    pushExp(2'b11, e);
    startRound(2'b11, 16'h9231, 16'h0F0F);
    waitIdle();

    // 3: board 1 ID error, its command registers keep the old value
    bReg[1][3] = 16'h5562;
    e = '{com0: 32'hE1C3C3E1, com1: 32'h56781234, err: 2'b10, acc0: 4, acc1: 1,
          wc0: 1, wc1: 0, wv0: 16'hFFFE, wv1: 16'h0};
    pushExp(2'b11, e);
    startRound(2'b11, 16'h0001, 16'hFFFF);
    waitIdle();

    // both boards fail: password in low byte only
    setBoard(0, 16'h00A4, 16'h1111, 16'h2222);
    e = '{com0: 32'hE1C3C3E1, com1: 32'h56781234, err: 2'b11, acc0: 1, acc1: 1,
          wc0: 0, wc1: 0, wv0: 16'h0, wv1: 16'h0};
    pushExp(2'b11, e);
    startRound(2'b11, 16'h5A5A, 16'hA5A5);
    waitIdle();

    // 5: recovery, extra iStart pulses mid-round and in the DONE clock
    setBoard(0, 16'hA4FF, 16'hAAAA, 16'h5555);
    setBoard(1, 16'hA4A4, 16'h0001, 16'h8000);
    e = '{com0: 32'h5555AAAA, com1: 32'h80000001, err: 2'b00, acc0: 4, acc1: 4,
          wc0: 1, wc1: 1, wv0: 16'h0000, wv1: 16'hEDCB};
    pushExp(2'b11, e);
    startRound(2'b11, 16'hFFFF, 16'h1234);
    repeat (10) @(posedge clk);
    #1 start = 2'b01;
    @(posedge clk); #1 start = 2'b00;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done[0]) break;
    end
    start = 2'b01;
    @(posedge clk); #1 start = 2'b00;
    repeat (80) @(posedge clk);

    // 6: reset in clock 20 of a round (STROBE of the third access)
    @(posedge clk); #1 start = 2'b01;
    @(posedge clk); #1 start = 2'b00;
    repeat (19) @(posedge clk);
    #1 iRes = 1'b1;
    @(posedge clk); #1 iRes = 1'b0;
    repeat (5) @(posedge clk);

    endReq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (endAck) break;
    end
    #1;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
